ifmap_buf_server: RTL and testbench

//  Responder side of the data_router read interface. Accepts ifmap pixels from the DRAM read stream
//  (valid/ready) and fills a two-bank ping-pong row buffer, POY row-groups x BUFH rows x BUFW pixels per bank.

---
 rtl/ifmap_buf_pkg.sv | 29 ++
 rtl/ifmap_bank_store.sv | 42 ++++
 rtl/ifmap_buf_server.sv | 168 ++++++++++++++++
 tb/tb_ifmap_buf_server.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifmap_buf_pkg.sv
// Shared types and constants for the ifmap ping-pong row buffer.
//   DW/POY/BUFW/STRIDE/BUFH : buffer geometry (pixel width, row groups, row length, rows)
//   X_W/P_W/R_W             : write-counter widths
//   bank_st_e               : per-bank fill state
//   RP_*                    : data_router read-op encodings on rpsel
package ifmap_buf_pkg;

    localparam int DW     = 32;
    localparam int POY    = 3;
    localparam int BUFW   = 48;
    localparam int STRIDE = 2;
    localparam int BUFH   = STRIDE + 1;

    localparam int X_W = $clog2(BUFW);
    localparam int P_W = $clog2(POY);
    localparam int R_W = $clog2(BUFH);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_st_e;

    localparam logic [1:0] RP_IDLE = 2'b00;
    localparam logic [1:0] RP_DW   = 2'b01;
    localparam logic [1:0] RP_PW   = 2'b10;
    localparam logic [1:0] RP_REL  = 2'b11;

endpackage

// File: rtl/ifmap_bank_store.sv
// One bank of the ifmap row buffer: POY row-groups x BUFH rows x BUFW pixels.
// Ports:
//   clk      in   clock
//   we       in   write enable for one pixel
//   wp/wr/wx in   write address (group, row, column)
//   wdata    in   pixel to write
//   rd_row   in   row to present on rd_data (all groups, all columns)
//   rd_data  out  combinational row window, zero when rd_row is out of range
// The array is not reset: unwritten entries are expected to keep stale contents.
module ifmap_bank_store
    import ifmap_buf_pkg::*;
(
    input  logic                               clk,
    input  logic                               we,
    input  logic [P_W-1:0]                     wp,
    input  logic [R_W-1:0]                     wr,
    input  logic [X_W-1:0]                     wx,
    input  logic [DW-1:0]                      wdata,
    input  logic [R_W-1:0]                     rd_row,
    output logic [POY-1:0][BUFW-1:0][DW-1:0]   rd_data
);

    logic [DW-1:0] mem [POY][BUFH][BUFW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wp][wr][wx] <= wdata;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_row < R_W'(BUFH)) begin
            for (int p = 0; p < POY; p++) begin
                for (int x = 0; x < BUFW; x++) begin
                    rd_data[p][x] = mem[p][rd_row][x];
                end
            end
        end
    end

endmodule

// File: rtl/ifmap_buf_server.sv
// Responder side of the data_router read interface. Fills a two-bank ping-pong
// row buffer from the ifmap DRAM stream and serves whole-row reads.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last  write stream; in_last closes the bank early
//   rpsel        00 idle, 01 dw read, 10 pw read, 11 release bank
//   bank, row    read target (bank[0] only, row 0..BUFH-1); col is ignored
//   data         registered row window, data[p][x] = buf[bank][p][row][x]
//   blkend       one-cycle pulse when a bank becomes FULL
//   bank_full    per-bank FULL flags
//   rd_err       sticky: read/release of a non-FULL bank or row out of range
//
// Bank states:
//   state   | meaning
//   EMPTY   | free, next accepted word starts a fill
//   FILLING | partially written, current write target
//   FULL    | complete, readable, waits for release
module ifmap_buf_server
    import ifmap_buf_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DW-1:0]                      in_data,
    input  logic                               in_last,
    input  logic [1:0]                         rpsel,
    input  logic [7:0]                         bank,
    input  logic [7:0]                         row,
    input  logic [27:0]                        col,
    output logic [POY-1:0][BUFW-1:0][DW-1:0]   data,
    output logic                               blkend,
    output logic [1:0]                         bank_full,
    output logic                               rd_err
);

    bank_st_e       st     [2];
    bank_st_e       st_nxt [2];
    logic           wbank;
    logic           wbank_nxt;
    logic [X_W-1:0] cnt_x;
    logic [P_W-1:0] cnt_p;
    logic [R_W-1:0] cnt_r;

    logic accept;
    logic last_word;
    logic complete;
    logic rbank;
    logic rd_op;
    logic rel_op;
    logic row_ok;
    logic rel_ok;
    logic rd_bad;

    logic [POY-1:0][BUFW-1:0][DW-1:0] rd_data0;
    logic [POY-1:0][BUFW-1:0][DW-1:0] rd_data1;
    logic [POY-1:0][BUFW-1:0][DW-1:0] rd_sel;

    // col and the upper bank bits are part of the router interface only
    logic unused_ifc;
    assign unused_ifc = ^{col, bank[7:1]};

    assign accept    = in_valid && in_ready;
    assign last_word = (cnt_r == R_W'(BUFH - 1)) &&
                       (cnt_p == P_W'(POY - 1))  &&
                       (cnt_x == X_W'(BUFW - 1));
    assign complete  = accept && (last_word || in_last);

    assign rbank  = bank[0];
    assign rd_op  = (rpsel == RP_DW) || (rpsel == RP_PW);
    assign rel_op = (rpsel == RP_REL);
    assign row_ok = (row < 8'(BUFH));
    assign rel_ok = rel_op && (st[rbank] == FULL);
    assign rd_bad = (rd_op && ((st[rbank] != FULL) || !row_ok)) ||
                    (rel_op && (st[rbank] != FULL));

    assign bank_full = {st[1] == FULL, st[0] == FULL};

    // A release and a completion can only hit different banks: the write bank
    // is never FULL while words are being accepted.
    always_comb begin
        st_nxt[0] = st[0];
        st_nxt[1] = st[1];
        if (accept) begin
            st_nxt[wbank] = complete ? FULL : FILLING;
        end
        if (rel_ok) begin
            st_nxt[rbank] = EMPTY;
        end
        wbank_nxt = complete ? ~wbank : wbank;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st[0]    <= EMPTY;
            st[1]    <= EMPTY;
            wbank    <= 1'b0;
            cnt_x    <= '0;
            cnt_p    <= '0;
            cnt_r    <= '0;
            in_ready <= 1'b1;
            blkend   <= 1'b0;
        end else begin
            st[0]    <= st_nxt[0];
            st[1]    <= st_nxt[1];
            wbank    <= wbank_nxt;
            // registered from next state so a release lets the stream resume one cycle later
            in_ready <= (st_nxt[wbank_nxt] != FULL);
            blkend   <= complete;
            if (complete) begin
                cnt_x <= '0;
                cnt_p <= '0;
                cnt_r <= '0;
            end else if (accept) begin
                if (cnt_x == X_W'(BUFW - 1)) begin
                    cnt_x <= '0;
                    if (cnt_p == P_W'(POY - 1)) begin
                        cnt_p <= '0;
                        cnt_r <= cnt_r + 1'b1;
                    end else begin
                        cnt_p <= cnt_p + 1'b1;
                    end
                end else begin
                    cnt_x <= cnt_x + 1'b1;
                end
            end
        end
    end

    ifmap_bank_store u_bank0 (
        .clk     (clk),
        .we      (accept && !wbank),
        .wp      (cnt_p),
        .wr      (cnt_r),
        .wx      (cnt_x),
        .wdata   (in_data),
        .rd_row  (row[R_W-1:0]),
        .rd_data (rd_data0)
    );

    ifmap_bank_store u_bank1 (
        .clk     (clk),
        .we      (accept && wbank),
        .wp      (cnt_p),
        .wr      (cnt_r),
        .wx      (cnt_x),
        .wdata   (in_data),
        .rd_row  (row[R_W-1:0]),
        .rd_data (rd_data1)
    );

    assign rd_sel = rbank ? rd_data1 : rd_data0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data   <= '0;
            rd_err <= 1'b0;
        end else begin
            if (rd_op) begin
                data <= row_ok ? rd_sel : '0;
            end
            if (rd_bad) begin
                rd_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ifmap_buf_server.sv
module tb_ifmap_buf_server;
    import ifmap_buf_pkg::*;

    localparam int BIG = 1 << 30;

    logic                             clk = 1'b0;
    logic                             rst_n = 1'b0;
    logic                             in_valid = 1'b0;
    logic                             in_ready;
    logic [DW-1:0]                    in_data = '0;
    logic                             in_last = 1'b0;
    logic [1:0]                       rpsel = RP_IDLE;
    logic [7:0]                       bank = '0;
    logic [7:0]                       row = '0;
    logic [27:0]                      col = '0;
    logic [POY-1:0][BUFW-1:0][DW-1:0] data;
    logic                             blkend;
    logic [1:0]                       bank_full;
    logic                             rd_err;

    ifmap_buf_server dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .rpsel     (rpsel),
        .bank      (bank),
        .row       (row),
        .col       (col),
        .data      (data),
        .blkend    (blkend),
        .bank_full (bank_full),
        .rd_err    (rd_err)
    );

    always #5 clk = ~clk;

    // expected row window: pixel i=48p+x reads base+i below lim, stale+i above
    typedef struct {
        string name;
        bit    zero;
        int    base;
        int    lim;
        int    stale;
        bit    err;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [1:0] blk_q[$];
    int         n_cmp = 0;
    int         n_mis = 0;
    logic       rd_chk = 1'b0;
    logic       rd_chk_q = 1'b0;

    always @(posedge clk) rd_chk_q <= rd_chk;

    function automatic rd_exp_t mk(string nm, bit z, int b, int l, int s, bit e);
        rd_exp_t r;
        r.name = nm; r.zero = z; r.base = b; r.lim = l; r.stale = s; r.err = e;
        return r;
    endfunction

    function automatic int exp_pix(rd_exp_t e, int p, int x);
        int i;
        i = BUFW * p + x;
        if (e.zero) return 0;
        return ((i < e.lim) ? e.base : e.stale) + i;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin : mon
        rd_exp_t    e;
        logic [1:0] eb;
        int         bad;
        int         bp, bx;
        if (rst_n) begin
            if (blkend) begin
                n_cmp++;
                if (blk_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL blkend_unexpected: got blkend=1 required no pulse");
                end else begin
                    eb = blk_q.pop_front();
                    if (bank_full !== eb) begin
                        n_mis++;
                        $display("FAIL blkend_bank_full: got %b required %b", bank_full, eb);
                    end
                end
            end
            if (rd_chk_q) begin
                if (rd_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL rd_unexpected: got a read with no expectation required none");
                end else begin
                    e = rd_q.pop_front();
                    bad = 0; bp = 0; bx = 0;
                    for (int p = 0; p < POY; p++) begin
                        for (int x = 0; x < BUFW; x++) begin
                            if (data[p][x] !== 32'(exp_pix(e, p, x))) begin
                                if (bad == 0) begin bp = p; bx = x; end
                                bad++;
                            end
                        end
                    end
                    n_cmp++;
                    if (bad != 0) begin
                        n_mis++;
                        $display("FAIL %s_data: data[%0d][%0d] got %0d required %0d (%0d bad pixels)",
                                 e.name, bp, bx, data[bp][bx], exp_pix(e, bp, bx), bad);
                    end
                    n_cmp++;
                    if (rd_err !== e.err) begin
                        n_mis++;
                        $display("FAIL %s_rd_err: got %b required %b", e.name, rd_err, e.err);
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input bit last, output bit ok);
        int  n;
        bit  rdy;
        n  = 0;
        ok = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last;
        forever begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) break;
            n++;
            if (n > 50) begin ok = 1'b0; break; end
            @(negedge clk);
        end
    endtask

    task automatic stream(input int base, input int n, input bit last_end,
                          input bit push, input logic [1:0] exp_bf);
        bit ok;
        for (int k = 0; k < n; k++) begin
            send(32'(base + k), last_end && (k == n - 1), ok);
            if (!ok) begin
                n_cmp++;
                n_mis++;
                $display("FAIL stream_stall: word %0d got no handshake required accept", base + k);
                break;
            end
            if (push && (k == n - 1)) blk_q.push_back(exp_bf);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic op(input logic [1:0] o, input logic b, input int r, input rd_exp_t e);
        @(negedge clk);
        rpsel = o; bank = {7'd0, b}; row = 8'(r); col = 28'h1234567; rd_chk = 1'b1;
        rd_q.push_back(e);
        @(posedge clk);
        #1;
        rpsel = RP_IDLE; rd_chk = 1'b0;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    endtask

    initial begin
        #400000;
        n_mis++;
        $display("FAIL watchdog: got timeout required completion");
        summary();
        $finish;
    end

    initial begin
        rd_exp_t e;

        // 1: reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_blkend", 32'(blkend), 0);
        chk("rst_bank_full", 32'(bank_full), 0);
        chk("rst_rd_err", 32'(rd_err), 0);
        chk("rst_data_nonzero", 32'(data != '0), 0);
        rst_n = 1'b1;

        // 2: full bank0 fill
        stream(0, 432, 1'b0, 1'b1, 2'b01);
        chk("t2_in_ready", 32'(in_ready), 1);

        // 3: reads of bank0
        op(RP_DW, 1'b0, 1, mk("t3_row1", 0, 144, BIG, 0, 0));
        @(negedge clk);
        chk("t3_data_2_47", data[2][47], 287);
        op(RP_PW, 1'b0, 0, mk("t3_row0", 0, 0, BIG, 0, 0));
        op(RP_DW, 1'b0, 2, mk("t3_row2", 0, 288, BIG, 0, 0));

        // 4: fill bank1, stall, release bank0
        stream(432, 432, 1'b0, 1'b1, 2'b11);
        chk("t4_ready_low", 32'(in_ready), 0);
        in_valid = 1'b1; in_data = 32'hDEAD;
        repeat (4) @(negedge clk);
        chk("t4_still_stalled", 32'(in_ready), 0);
        in_valid = 1'b0;
        e = mk("t4_b1_row0", 0, 432, BIG, 0, 0);
        op(RP_DW, 1'b1, 0, e);
        e.name = "t4_rel_b0";
        op(RP_REL, 1'b0, 0, e);
        @(negedge clk);
        chk("t4_bank_full", 32'(bank_full), 32'b10);
        chk("t4_ready_high", 32'(in_ready), 1);

        // 5: early close of bank1 via in_last, reads of empty bank
        e.name = "t5_rel_b1";
        op(RP_REL, 1'b1, 0, e);
        @(negedge clk);
        chk("t5_both_empty", 32'(bank_full), 0);
        stream(1000, 432, 1'b0, 1'b1, 2'b01);
        stream(0, 100, 1'b1, 1'b1, 2'b11);
        op(RP_DW, 1'b1, 0, mk("t5_b1_row0", 0, 0, 100, 432, 0));
        @(negedge clk);
        chk("t5_data_2_3", data[2][3], 99);
        e = mk("t5_b1_row2", 0, 720, BIG, 0, 0);
        op(RP_PW, 1'b1, 2, e);
        e.name = "t5_rel_b0";
        op(RP_REL, 1'b0, 0, e);
        @(negedge clk);
        chk("t5_bank_full", 32'(bank_full), 32'b10);
        e = mk("t5_rd_empty_b0", 0, 1000, BIG, 0, 1);
        op(RP_DW, 1'b0, 0, e);
        e.name = "t5_hold";
        op(RP_IDLE, 1'b0, 0, e);
        op(RP_DW, 1'b1, 3, mk("t5_row_oob", 1, 0, BIG, 0, 1));
        e = mk("t5_b1_row1", 0, 576, BIG, 0, 1);
        op(RP_PW, 1'b1, 1, e);
        e.name = "t5_rel_empty";
        op(RP_REL, 1'b0, 0, e);

        // 6: reset mid-fill, then fresh fill lands in bank0
        stream(3000, 200, 1'b0, 1'b0, 2'b00);
        rst_n = 1'b0;
        #1;
        chk("t6_in_ready", 32'(in_ready), 1);
        chk("t6_bank_full", 32'(bank_full), 0);
        chk("t6_blkend", 32'(blkend), 0);
        chk("t6_rd_err", 32'(rd_err), 0);
        chk("t6_data_nonzero", 32'(data != '0), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stream(2000, 432, 1'b0, 1'b1, 2'b01);
        op(RP_DW, 1'b0, 2, mk("t6_b0_row2", 0, 2288, BIG, 0, 0));

        repeat (2) @(negedge clk);
        chk("end_blk_q_left", 32'(blk_q.size()), 0);
        chk("end_rd_q_left", 32'(rd_q.size()), 0);
        summary();
        $finish;
    end

endmodule
